// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM encoding, mem_sel codes and byte-enable decode for the data-SRAM controller
package sram_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_BYTE = 2'b01;
  localparam logic [1:0] SEL_HALF = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;
  function automatic logic [3:0] sel_to_be_n(input logic [1:0] sel);
    return sel == SEL_BYTE ? 4'b1110 :
           sel == SEL_HALF ? 4'b1100 :
           sel == SEL_WORD ? 4'b0000 : 4'b1111;
  endfunction
endpackage

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: word-wide asynchronous SRAM controller with programmable read wait and write pulse
module data_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ce,
  input  logic              write_ce,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic [1:0]        mem_sel,
  output logic [31:0]       rdata,
  output logic              rfin,
  output logic              wfin,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);
  localparam int CW = $clog2((RD_WAIT > WR_PULSE ? RD_WAIT : WR_PULSE) + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic op_wr, op_wr_d;
  logic [31:0] rdata_d, dq_d;
  logic [ADDR_W-1:0] addr_d;
  logic rfin_d, wfin_d, busy_d, dq_oe_d, ce_n_d, oe_n_d, we_n_d;
  logic [3:0] be_n_d;
  logic unused_addr;
  assign unused_addr = ^address[31:ADDR_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      rdata      <= '0;
      rfin       <= 1'b0;
      wfin       <= 1'b0;
      busy       <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_wr      <= op_wr_d;
      rdata      <= rdata_d;
      rfin       <= rfin_d;
      wfin       <= wfin_d;
      busy       <= busy_d;
      sram_addr  <= addr_d;
      sram_dq_o  <= dq_d;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_be_n  <= be_n_d;
    end
  end
  // Every output is a register; this block only computes their next values.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_wr_d = op_wr;
    rdata_d = rdata;
    rfin_d  = rfin;
    wfin_d  = wfin;
    addr_d  = sram_addr;
    dq_d    = sram_dq_o;
    dq_oe_d = sram_dq_oe;
    ce_n_d  = sram_ce_n;
    oe_n_d  = sram_oe_n;
    we_n_d  = sram_we_n;
    be_n_d  = sram_be_n;
    case (state)
      ST_IDLE: if (write_ce || read_ce) begin
        op_wr_d = write_ce;
        addr_d  = address[ADDR_W-1:0];
        dq_d    = wdata;
        if (write_ce && mem_sel == SEL_NONE) begin
          state_d = ST_DONE;
          wfin_d  = 1'b1;
        end else if (write_ce) begin
          state_d = ST_WR_SETUP;
          ce_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          be_n_d  = sel_to_be_n(mem_sel);
        end else begin
          state_d = ST_RD;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          be_n_d  = 4'h0;
          cnt_d   = CW'(RD_WAIT - 1);
        end
      end
      ST_RD: if (cnt == '0) begin
        state_d = ST_DONE;
        rdata_d = sram_dq_i;
        rfin_d  = 1'b1;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        be_n_d  = 4'hF;
      end else cnt_d = cnt - 1'b1;
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = CW'(WR_PULSE - 1);
      end
      ST_WR_PULSE: if (cnt == '0) begin
        state_d = ST_WR_HOLD;
        we_n_d  = 1'b1;
      end else cnt_d = cnt - 1'b1;
      ST_WR_HOLD: begin
        state_d = ST_DONE;
        wfin_d  = 1'b1;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = 4'hF;
      end
      ST_DONE: if (!(op_wr ? write_ce : read_ce)) begin
        state_d = ST_IDLE;
        rfin_d  = 1'b0;
        wfin_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_d != ST_IDLE;
  end
endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb_data_sram_ctrl: randomized and directed checks of data_sram_ctrl against an SRAM model and reference memory
module tb_data_sram_ctrl;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;
  logic clk = 1'b0;
  logic rst, read_ce, write_ce;
  logic [31:0] address, wdata, rdata, sram_dq_o, sram_dq_i;
  logic [1:0] mem_sel;
  logic rfin, wfin, busy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  logic [3:0] sram_be_n;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int stray = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  data_sram_ctrl #(.ADDR_W(20), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .clk(clk), .rst(rst), .read_ce(read_ce), .write_ce(write_ce), .address(address),
    .wdata(wdata), .mem_sel(mem_sel), .rdata(rdata), .rfin(rfin), .wfin(wfin), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
  end

  always @(negedge clk) begin
    if (!rst && sram_dq_oe && !sram_oe_n) overlap++;
    if (!rst && !sram_we_n && sram_ce_n) stray++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] d, input logic [1:0] sel);
    return sel == 2'd1 ? {old[31:8], d[7:0]} : sel == 2'd2 ? {old[31:16], d[15:0]} : sel == 2'd3 ? d : old;
  endfunction

  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sel, input int drop_after, input int hold,
                        output int fin_at, output int rf_n, output int wf_n, output int we_cnt,
                        output int oe_cnt, output int ce_cnt, output logic [3:0] be_obs,
                        output logic [19:0] addr_obs);
    fin_at = -1; rf_n = 0; wf_n = 0; we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
    be_obs = 4'hF; addr_obs = '0;
    address = a; wdata = d; mem_sel = sel; write_ce = wr; read_ce = rd;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (k == 1) begin
        address = $urandom;
        wdata = $urandom;
      end
      if (!sram_we_n) begin
        we_cnt++;
        be_obs = sram_be_n;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_ce_n) begin
        ce_cnt++;
        addr_obs = sram_addr;
      end
      if (rfin) rf_n++;
      if (wfin) wf_n++;
      if ((rfin || wfin) && fin_at < 0) fin_at = k;
      if (k == drop_after || rf_n + wf_n >= hold) begin
        read_ce = 1'b0;
        write_ce = 1'b0;
      end
      if (fin_at > 0 && !rfin && !wfin && !busy) break;
    end
    read_ce = 1'b0;
    write_ce = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({rdata, rfin, wfin, busy, sram_addr, sram_dq_o, sram_dq_oe} !== {32'h0, 3'b000, 20'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_data: got rdata=%h rfin=%b wfin=%b busy=%b addr=%h dq=%h oe=%b want all zero",
               rdata, rfin, wfin, busy, sram_addr, sram_dq_o, sram_dq_oe);
    end
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin
      bad++;
      $display("FAIL reset_strobes: got ce=%b oe=%b we=%b be=%b want 1 1 1 1111",
               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n);
    end
    rst = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || sram_ce_n !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b ce=%b want 0 1", busy, sram_ce_n);
    end
    exp_rdata = 32'h0;
  endtask

  task automatic test_word_read;
    int fin_at, rf_n, wf_n, we_c, oe_c, ce_c;
    logic [3:0] be;
    logic [19:0] ad;
    mem[10'h12] = 32'hDEADBEEF;
    ref_mem[10'h12] = 32'hDEADBEEF;
    run_op(1'b0, 1'b1, 32'h12, 32'h0, 2'b11, 0, 1, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
    exp_rdata = 32'hDEADBEEF;
    total++;
    if (rdata !== exp_rdata) begin
      bad++;
      $display("FAIL word_read_data: got %h want %h", rdata, exp_rdata);
    end
    total++;
    if (fin_at !== RD_WAIT + 1 || oe_c !== RD_WAIT || rf_n !== 1 || wf_n !== 0) begin
      bad++;
      $display("FAIL word_read_timing: got fin_at=%0d oe=%0d rfin=%0d wfin=%0d want %0d %0d 1 0",
               fin_at, oe_c, rf_n, wf_n, RD_WAIT + 1, RD_WAIT);
    end
    total++;
    if (busy !== 1'b0 || ad !== 20'h12) begin
      bad++;
      $display("FAIL word_read_end: got busy=%b addr=%h want 0 00012", busy, ad);
    end
  endtask

  task automatic test_byte_write;
    int fin_at, rf_n, wf_n, we_c, oe_c, ce_c;
    logic [3:0] be;
    logic [19:0] ad;
    ref_mem[10'h40] = ref_write(ref_mem[10'h40], 32'h000000A5, 2'b01);
    run_op(1'b1, 1'b0, 32'h40, 32'h000000A5, 2'b01, 0, 1, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
    total++;
    if (be !== 4'b1110 || we_c !== WR_PULSE || oe_c !== 0) begin
      bad++;
      $display("FAIL byte_write_strobes: got be=%b we=%0d oe=%0d want 1110 %0d 0", be, we_c, oe_c, WR_PULSE);
    end
    total++;
    if (fin_at !== WR_PULSE + 3 || wf_n !== 1 || rf_n !== 0) begin
      bad++;
      $display("FAIL byte_write_timing: got fin_at=%0d wfin=%0d rfin=%0d want %0d 1 0",
               fin_at, wf_n, rf_n, WR_PULSE + 3);
    end
    total++;
    if (mem[10'h40] !== ref_mem[10'h40]) begin
      bad++;
      $display("FAIL byte_write_mem: got %h want %h", mem[10'h40], ref_mem[10'h40]);
    end
  endtask

  task automatic test_simultaneous;
    int fin_at, rf_n, wf_n, we_c, oe_c, ce_c;
    logic [3:0] be;
    logic [19:0] ad;
    ref_mem[10'h55] = 32'h12345678;
    run_op(1'b1, 1'b1, 32'h55, 32'h12345678, 2'b11, 0, 1, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
    total++;
    if (rf_n !== 0 || wf_n !== 1 || mem[10'h55] !== 32'h12345678) begin
      bad++;
      $display("FAIL simultaneous: got rfin=%0d wfin=%0d mem=%h want 0 1 12345678", rf_n, wf_n, mem[10'h55]);
    end
    total++;
    if (rdata !== exp_rdata) begin
      bad++;
      $display("FAIL write_keeps_rdata: got %h want %h", rdata, exp_rdata);
    end
  endtask

  task automatic test_reset_mid_write;
    int seen_we = 0;
    int wf = 0;
    address = 32'h77; wdata = 32'hCAFEF00D; mem_sel = 2'b11; write_ce = 1'b1;
    for (int k = 0; k < 10 && seen_we == 0; k++) begin
      tick;
      if (wfin) wf++;
      if (!sram_we_n) seen_we = 1;
    end
    total++;
    if (seen_we !== 1) begin
      bad++;
      $display("FAIL mid_write_pulse: got we_seen=%0d want 1", seen_we);
    end
    ref_mem[10'h77] = 32'hCAFEF00D;
    rst = 1'b1;
    tick;
    total++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe, busy, wfin} !== 5'b11000) begin
      bad++;
      $display("FAIL mid_write_reset: got we=%b ce=%b dq_oe=%b busy=%b wfin=%b want 1 1 0 0 0",
               sram_we_n, sram_ce_n, sram_dq_oe, busy, wfin);
    end
    rst = 1'b0;
    write_ce = 1'b0;
    tick;
    if (wfin) wf++;
    exp_rdata = 32'h0;
    total++;
    if (wf !== 0 || busy !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_write_after: got wfin_cycles=%0d busy=%b rdata=%h want 0 0 0", wf, busy, rdata);
    end
  endtask

  task automatic test_noop_and_abandon;
    int fin_at, rf_n, wf_n, we_c, oe_c, ce_c;
    logic [3:0] be;
    logic [19:0] ad;
    run_op(1'b1, 1'b0, 32'h99, 32'hFFFFFFFF, 2'b00, 0, 1, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
    total++;
    if (ce_c !== 0 || we_c !== 0 || fin_at !== 1 || wf_n !== 1) begin
      bad++;
      $display("FAIL noop_write: got ce=%0d we=%0d fin_at=%0d wfin=%0d want 0 0 1 1", ce_c, we_c, fin_at, wf_n);
    end
    total++;
    if (mem[10'h99] !== ref_mem[10'h99]) begin
      bad++;
      $display("FAIL noop_mem: got %h want %h", mem[10'h99], ref_mem[10'h99]);
    end
    run_op(1'b0, 1'b1, 32'h40, 32'h0, 2'b11, 1, 5, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
    exp_rdata = ref_mem[10'h40];
    total++;
    if (fin_at !== RD_WAIT + 1 || rf_n !== 1 || rdata !== exp_rdata) begin
      bad++;
      $display("FAIL abandoned_read: got fin_at=%0d rfin=%0d rdata=%h want %0d 1 %h",
               fin_at, rf_n, rdata, RD_WAIT + 1, exp_rdata);
    end
  endtask

  task automatic test_random;
    int fin_at, rf_n, wf_n, we_c, oe_c, ce_c, op, drop, hold, exp_len, exp_fin;
    logic [3:0] be, exp_be;
    logic [19:0] ad;
    logic [9:0] idx;
    logic [31:0] a, d;
    logic [1:0] sel;
    logic wr, noop;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 2);
      sel = 2'($urandom_range(0, 3));
      idx = 10'($urandom_range(0, 1023));
      a = {12'($urandom), 10'd0, idx};
      d = $urandom;
      drop = $urandom_range(0, 1);
      hold = $urandom_range(1, 3);
      wr = op != 0;
      noop = wr && sel == 2'b00;
      exp_len = drop != 0 ? 1 : hold;
      exp_fin = noop ? 1 : wr ? WR_PULSE + 3 : RD_WAIT + 1;
      exp_be = sel == 2'b01 ? 4'b1110 : sel == 2'b10 ? 4'b1100 : 4'b0000;
      if (wr) ref_mem[idx] = ref_write(ref_mem[idx], d, sel);
      else exp_rdata = ref_mem[idx];
      run_op(wr, op != 1, a, d, sel, drop, hold, fin_at, rf_n, wf_n, we_c, oe_c, ce_c, be, ad);
      total++;
      if (fin_at !== exp_fin || rf_n !== (wr ? 0 : exp_len) || wf_n !== (wr ? exp_len : 0)) begin
        bad++;
        $display("FAIL rand_handshake[%0d]: got fin_at=%0d rfin=%0d wfin=%0d want %0d %0d %0d",
                 i, fin_at, rf_n, wf_n, exp_fin, wr ? 0 : exp_len, wr ? exp_len : 0);
      end
      total++;
      if (we_c !== (wr && !noop ? WR_PULSE : 0) || oe_c !== (wr ? 0 : RD_WAIT) ||
          ce_c !== (noop ? 0 : wr ? WR_PULSE + 2 : RD_WAIT)) begin
        bad++;
        $display("FAIL rand_strobes[%0d]: got we=%0d oe=%0d ce=%0d op=%0d sel=%0d", i, we_c, oe_c, ce_c, op, sel);
      end
      if (wr && !noop) begin
        total++;
        if (be !== exp_be || ad !== a[19:0]) begin
          bad++;
          $display("FAIL rand_be_addr[%0d]: got be=%b addr=%h want %b %h", i, be, ad, exp_be, a[19:0]);
        end
      end
      total++;
      if (rdata !== exp_rdata || mem[idx] !== ref_mem[idx]) begin
        bad++;
        $display("FAIL rand_data[%0d]: got rdata=%h mem=%h want %h %h", i, rdata, mem[idx], exp_rdata, ref_mem[idx]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; read_ce = 1'b0; write_ce = 1'b0; address = '0; wdata = '0; mem_sel = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_word_read;
    test_byte_write;
    test_simultaneous;
    test_reset_mid_write;
    test_noop_and_abandon;
    test_random;
    total++;
    if (overlap !== 0 || stray !== 0) begin
      bad++;
      $display("FAIL bus_contention: got oe_overlap=%0d stray_we=%0d want 0 0", overlap, stray);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
